vga_pixel_double_buffer: RTL and testbench

- Ping-pong line-fragment store between the VGA bus-fetch FSM (upstream) and the VGA colour/DAC output stage (downstream).
- Burst words from the memory bus are written into the bank the display is not reading.
- The display side reads one byte per pixel from the selected bank through a registered pipeline.
- Tracks per-bank fill status, substitutes a blank colour on underrun, and counts underruns for debug.

---
 rtl/vga_pixel_double_buffer.sv | 133 +++++++++++++
 tb/tb_vga_pixel_double_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_double_buffer.sv
// vga_pixel_double_buffer
//   Ping-pong line-fragment store between the VGA bus-fetch FSM and the
//   colour/DAC output stage. Burst words are written into one bank while the
//   display reads pixels (one byte per pixel) from the other through a
//   single output register. Each bank carries a fill flag. An unfilled read
//   bank produces BLANK_COLOR and counts as an underrun.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   bus_in            burst data word (two 8-bit pixels)
//   buf0_we/buf1_we   write bus_in into bank 0/1 at buf_write_addr
//   buf_write_addr    word address for writes
//   buf_sel           bank the display reads
//   buf_read_addr     word address for display reads
//   buf_byte_sel      1 = high byte (even pixel), 0 = low byte
//   vga_output_valid  display is in the active region
//   underrun_clr      clears underrun_count and underrun_flag
//   pixel_out         registered pixel colour
//   pixel_valid       registered copy of vga_output_valid
//   bank_full         per-bank fill status, bit n = bank n
//   underrun_flag     sticky underrun indicator
//   underrun_count    saturating underrun counter
module vga_pixel_double_buffer #(
    parameter int          DEPTH       = 8,
    parameter int          AW          = 3,
    parameter int          DW          = 16,
    parameter logic [7:0]  BLANK_COLOR = 8'h00
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] bus_in,
    input  logic          buf0_we,
    input  logic          buf1_we,
    input  logic [AW-1:0] buf_write_addr,
    input  logic          buf_sel,
    input  logic [AW-1:0] buf_read_addr,
    input  logic          buf_byte_sel,
    input  logic          vga_output_valid,
    input  logic          underrun_clr,
    output logic [7:0]    pixel_out,
    output logic          pixel_valid,
    output logic [1:0]    bank_full,
    output logic          underrun_flag,
    output logic [15:0]   underrun_count
);

    logic [DW-1:0] r_bank0 [DEPTH];
    logic [DW-1:0] r_bank1 [DEPTH];

    logic          r_sel_q;
    logic [1:0]    r_bank_full;
    logic [7:0]    r_pixel;
    logic          r_pixel_valid;
    logic          r_underrun_flag;
    logic [15:0]   r_underrun_count;

    logic [DW-1:0] w_rd_word;
    logic [7:0]    w_rd_byte;
    logic          w_full_sel;
    logic          w_underrun;
    logic [1:0]    w_set;
    logic [1:0]    w_leave;
    logic [1:0]    w_full_next;

    // Bank storage: no reset on contents; reset still blocks writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (buf0_we) r_bank0[buf_write_addr] <= bus_in;
            if (buf1_we) r_bank1[buf_write_addr] <= bus_in;
        end
    end

    // Asynchronous read of the selected bank; the array update is registered,
    // so a same-address write in this cycle is not yet visible (read-first).
    always_comb begin
        w_rd_word = '0;
        if (buf_sel) w_rd_word = r_bank1[buf_read_addr];
        else         w_rd_word = r_bank0[buf_read_addr];
    end

    assign w_rd_byte  = buf_byte_sel ? w_rd_word[15:8] : w_rd_word[7:0];
    assign w_full_sel = r_bank_full[buf_sel];
    assign w_underrun = vga_output_valid && !w_full_sel;

    // Fill flags: a write to the last word sets, leaving the bank clears,
    // and set wins when both happen in one cycle.
    always_comb begin
        w_set       = '0;
        w_leave     = '0;
        w_set[0]    = buf0_we && (buf_write_addr == AW'(DEPTH - 1));
        w_set[1]    = buf1_we && (buf_write_addr == AW'(DEPTH - 1));
        w_leave[0]  = !r_sel_q &&  buf_sel;
        w_leave[1]  =  r_sel_q && !buf_sel;
        w_full_next = w_set | (r_bank_full & ~w_leave);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_q       <= 1'b0;
            r_bank_full   <= '0;
            r_pixel       <= '0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_sel_q       <= buf_sel;
            r_bank_full   <= w_full_next;
            r_pixel_valid <= vga_output_valid;
            if (!vga_output_valid) r_pixel <= '0;
            else if (w_full_sel)   r_pixel <= w_rd_byte;
            else                   r_pixel <= BLANK_COLOR;
        end
    end

    // Underrun bookkeeping: clear beats increment, counter saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun_flag  <= 1'b0;
            r_underrun_count <= '0;
        end else if (underrun_clr) begin
            r_underrun_flag  <= 1'b0;
            r_underrun_count <= '0;
        end else if (w_underrun) begin
            r_underrun_flag <= 1'b1;
            if (r_underrun_count != '1) r_underrun_count <= r_underrun_count + 16'd1;
        end
    end

    assign pixel_out      = r_pixel;
    assign pixel_valid    = r_pixel_valid;
    assign bank_full      = r_bank_full;
    assign underrun_flag  = r_underrun_flag;
    assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_vga_pixel_double_buffer.sv
// tb_vga_pixel_double_buffer
//   Directed bench for vga_pixel_double_buffer. A behavioural model tracks
//   bank contents, fill flags and underrun counters and is compared against
//   the DUT on every cycle after the first reset edge. Hand-computed literal
//   checks pin key values along the way.
module tb_vga_pixel_double_buffer;

    localparam int         DEPTH = 8;
    localparam int         AW    = 3;
    localparam int         DW    = 16;
    localparam logic [7:0] BLANK = 8'h00;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] bus_in;
    logic          buf0_we, buf1_we;
    logic [AW-1:0] buf_write_addr;
    logic          buf_sel;
    logic [AW-1:0] buf_read_addr;
    logic          buf_byte_sel;
    logic          vga_output_valid;
    logic          underrun_clr;
    logic [7:0]    pixel_out;
    logic          pixel_valid;
    logic [1:0]    bank_full;
    logic          underrun_flag;
    logic [15:0]   underrun_count;

    int n_cmp = 0;
    int n_bad = 0;

    vga_pixel_double_buffer #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .BLANK_COLOR(BLANK)
    ) dut (
        .clk(clk), .reset(reset), .bus_in(bus_in),
        .buf0_we(buf0_we), .buf1_we(buf1_we), .buf_write_addr(buf_write_addr),
        .buf_sel(buf_sel), .buf_read_addr(buf_read_addr), .buf_byte_sel(buf_byte_sel),
        .vga_output_valid(vga_output_valid), .underrun_clr(underrun_clr),
        .pixel_out(pixel_out), .pixel_valid(pixel_valid), .bank_full(bank_full),
        .underrun_flag(underrun_flag), .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    logic [DW-1:0] m_mem [2][DEPTH];
    bit            m_full [2];
    bit            m_selq;
    logic [7:0]    m_pix;
    bit            m_vld;
    bit            m_flag;
    int            m_cnt;
    bit            m_ready = 0;

    always @(posedge clk) begin
        bit           under;
        bit           we [2];
        logic [DW-1:0] word;
        we[0] = buf0_we;
        we[1] = buf1_we;
        if (reset) begin
            m_pix = 8'h00; m_vld = 0; m_full[0] = 0; m_full[1] = 0;
            m_flag = 0; m_cnt = 0; m_selq = 0; m_ready = 1;
        end else begin
            under = 0;
            // Display read sees memory and fill flags as they were before this edge.
            if (!vga_output_valid) m_pix = 8'h00;
            else if (m_full[buf_sel]) begin
                word  = m_mem[buf_sel][buf_read_addr];
                m_pix = buf_byte_sel ? word[15:8] : word[7:0];
            end else begin
                m_pix = BLANK;
                under = 1;
            end
            m_vld = vga_output_valid;
            if (underrun_clr) begin
                m_cnt = 0; m_flag = 0;
            end else if (under) begin
                m_flag = 1;
                if (m_cnt < 65535) m_cnt++;
            end
            for (int n = 0; n < 2; n++) begin
                if (we[n] && buf_write_addr == AW'(DEPTH - 1)) m_full[n] = 1;
                else if (m_selq == n[0] && buf_sel != n[0])   m_full[n] = 0;
                if (we[n]) m_mem[n][buf_write_addr] = bus_in;
            end
            m_selq = buf_sel;
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("cyc_pixel_out", 32'(pixel_out), 32'(m_pix));
            check("cyc_pixel_valid", 32'(pixel_valid), 32'(m_vld));
            check("cyc_bank_full", 32'(bank_full), 32'({m_full[1], m_full[0]}));
            check("cyc_underrun_flag", 32'(underrun_flag), 32'(m_flag));
            check("cyc_underrun_count", 32'(underrun_count), 32'(m_cnt));
        end
    end

    // Inputs change on the falling edge; tick returns after the next rising edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus_in = '0; buf0_we = 0; buf1_we = 0; buf_write_addr = '0;
        buf_read_addr = '0; buf_byte_sel = 0; vga_output_valid = 0; underrun_clr = 0;
    endtask

    task automatic fill(input bit b0, input bit b1, input logic [7:0] hi_base, input logic [7:0] lo_base);
        for (int i = 0; i < DEPTH; i++) begin
            buf0_we = b0; buf1_we = b1;
            buf_write_addr = AW'(i);
            bus_in = {hi_base + 8'(i), lo_base + 8'(i)};
            tick();
        end
        buf0_we = 0; buf1_we = 0;
    endtask

    initial begin
        idle_inputs();
        buf_sel = 0;
        reset   = 1;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            bus_in = 16'($urandom); buf0_we = 1'($urandom); buf1_we = 1'($urandom);
            buf_write_addr = 3'($urandom); buf_sel = 1'($urandom);
            buf_read_addr = 3'($urandom); buf_byte_sel = 1'($urandom);
            vga_output_valid = 1'($urandom); underrun_clr = 1'($urandom);
            tick();
        end
        check("rst_pixel_out", 32'(pixel_out), 32'h0);
        check("rst_pixel_valid", 32'(pixel_valid), 32'h0);
        check("rst_bank_full", 32'(bank_full), 32'h0);
        check("rst_underrun_flag", 32'(underrun_flag), 32'h0);
        check("rst_underrun_count", 32'(underrun_count), 32'h0);
        reset = 0;
        idle_inputs();
        buf_sel = 0;
        tick();

        // Fill bank 1 with A0B1..A7B8
        fill(0, 1, 8'hA0, 8'hB1);
        check("fill1_bank_full", 32'(bank_full), 32'h2);

        buf_sel = 1; vga_output_valid = 1; buf_read_addr = 3; buf_byte_sel = 1;
        tick();
        check("rd_a3_hi", 32'(pixel_out), 32'hA3);
        check("rd_a3_valid", 32'(pixel_valid), 32'h1);
        buf_byte_sel = 0;
        tick();
        check("rd_a3_lo", 32'(pixel_out), 32'hB4);

        // Read-first on a same-address write
        buf1_we = 1; buf_write_addr = 2; bus_in = 16'hCCDD;
        buf_read_addr = 2; buf_byte_sel = 1;
        tick();
        check("rd_first_old", 32'(pixel_out), 32'hA2);
        buf1_we = 0;
        tick();
        check("rd_after_new", 32'(pixel_out), 32'hCC);

        // Underrun on unfilled bank 0
        buf_sel = 0;
        repeat (5) tick();
        check("ur_pixel", 32'(pixel_out), 32'(BLANK));
        check("ur_count5", 32'(underrun_count), 32'd5);
        check("ur_flag", 32'(underrun_flag), 32'h1);
        vga_output_valid = 0; underrun_clr = 1;
        tick();
        check("ur_clr_count", 32'(underrun_count), 32'd0);
        check("ur_clr_flag", 32'(underrun_flag), 32'h0);
        vga_output_valid = 1;
        tick();
        check("ur_clr_vs_inc_count", 32'(underrun_count), 32'd0);
        check("ur_clr_vs_inc_flag", 32'(underrun_flag), 32'h0);
        underrun_clr = 0; vga_output_valid = 0;
        tick();

        // Swap clears status of the bank being left
        fill(1, 1, 8'h10, 8'h20);
        check("swap_both_full", 32'(bank_full), 32'h3);
        buf_sel = 1;
        tick();
        check("swap_0to1", 32'(bank_full), 32'h2);
        buf_sel = 0;
        tick();
        check("swap_1to0", 32'(bank_full), 32'h0);
        fill(1, 1, 8'h10, 8'h20);
        buf_sel = 1; buf0_we = 1; buf_write_addr = 7; bus_in = 16'h1727;
        tick();
        check("swap_set_wins", 32'(bank_full), 32'h3);
        buf0_we = 0;

        // Blanking with a full bank
        vga_output_valid = 1; buf_read_addr = 5; buf_byte_sel = 1;
        tick();
        check("blank_pre_read", 32'(pixel_out), 32'h15);
        vga_output_valid = 0;
        tick();
        check("blank_pixel", 32'(pixel_out), 32'h0);
        check("blank_valid", 32'(pixel_valid), 32'h0);
        check("blank_count", 32'(underrun_count), 32'd0);

        // Saturation
        reset = 1; buf_sel = 0;
        tick();
        reset = 0; vga_output_valid = 1;
        repeat (65534) tick();
        check("sat_fffe", 32'(underrun_count), 32'hFFFE);
        tick();
        check("sat_ffff", 32'(underrun_count), 32'hFFFF);
        repeat (2) tick();
        check("sat_hold", 32'(underrun_count), 32'hFFFF);
        check("sat_flag", 32'(underrun_flag), 32'h1);
        vga_output_valid = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
